// File: rtl/types_pkg.sv
// Shared mina_cpu pipeline types: operand selects, ALU/T ops, memory ops
// and the ID/EX and EX/MEM stage bundles.
package types_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {SEL_ZERO, SEL_REG, SEL_IMM, SEL_PC} sel_t;

  typedef enum logic [2:0] {
    ALU_OP_ADD, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
    ALU_OP_SHL, ALU_OP_SHR, ALU_OP_SAR
  } alu_op_t;

  typedef enum logic [1:0] {T_OP_SET, T_OP_EQ, T_OP_LT, T_OP_LTU} t_op_t;

  typedef enum logic [1:0] {MEM_OP_NONE, MEM_OP_LOAD, MEM_OP_STORE} mem_op_t;

  // An all-zero bundle is a bubble: ADD of zeros, T_OP_SET, no branch, no memory op.
  typedef struct packed {
    mem_op_t             mem_op;
    logic [REG_AW-1:0]   rd_addr;
    logic [REG_AW-1:0]   ra_addr;
    logic [REG_AW-1:0]   rb_addr;
    logic [XLEN-1:0]     ra_data;
    logic [XLEN-1:0]     rb_data;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     ia_plus_4;
    sel_t                a_sel;
    sel_t                b_sel;
    logic [4:0]          shift;
    logic                invert_b;
    alu_op_t             alu_op;
    t_op_t               t_op;
    logic                invert_t;
    logic                branch;
    logic                cond_branch;
  } ex_params_t;

  typedef struct packed {
    mem_op_t             mem_op;
    logic [XLEN-1:0]     result;
    logic [XLEN-1:0]     store_data;
    logic [REG_AW-1:0]   rd_addr;
  } mem_params_t;

  // r0 is hardwired to zero; otherwise MEM beats WB beats the register-file read.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [REG_AW-1:0] addr,
    input logic [XLEN-1:0]   rf_data,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_addr,
    input logic [XLEN-1:0]   mem_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_addr,
    input logic [XLEN-1:0]   wb_data
  );
    if (addr == '0)                        return '0;
    else if (mem_we && mem_addr == addr)   return mem_data;
    else if (wb_we && wb_addr == addr)     return wb_data;
    else                                   return rf_data;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: adder with carry/overflow flags plus logic and shift ops.
module alu
  import types_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  input  alu_op_t         alu_op,
  output logic [XLEN-1:0] result,
  output logic            carry,
  output logic            overflow
);

  logic [XLEN:0] sum;

  // Flags always come from the adder so compares work whatever alu_op says.
  assign sum      = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};
  assign carry    = sum[XLEN];
  assign overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    result = sum[XLEN-1:0];
    case (alu_op)
      ALU_OP_AND: result = a & b;
      ALU_OP_OR:  result = a | b;
      ALU_OP_XOR: result = a ^ b;
      ALU_OP_SHL: result = a << b[4:0];
      ALU_OP_SHR: result = a >> b[4:0];
      ALU_OP_SAR: result = $unsigned($signed(a) >>> b[4:0]);
      default:    result = sum[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// mina_cpu execute stage: forwarding, ALU, T flag, branch resolution and
// the EX/MEM pipeline register.
module ex_stage
  import types_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  ex_params_t        ex_params_in,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_addr,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_addr,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              valid,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_addr,
  output logic              t_flag,
  output mem_params_t       mem_params_out
);

  logic [XLEN-1:0] ra_val, rb_val;
  logic [XLEN-1:0] op_a, op_b_raw, op_b_shifted, op_b;
  logic [XLEN-1:0] alu_result, ex_result;
  logic            alu_carry, alu_overflow;
  logic            t_q, t_cmp, t_next, taken;
  mem_params_t     mem_q;

  assign ra_val = fwd_operand(ex_params_in.ra_addr, ex_params_in.ra_data,
                              mem_fwd_we, mem_fwd_addr, mem_fwd_data,
                              wb_fwd_we, wb_fwd_addr, wb_fwd_data);
  assign rb_val = fwd_operand(ex_params_in.rb_addr, ex_params_in.rb_data,
                              mem_fwd_we, mem_fwd_addr, mem_fwd_data,
                              wb_fwd_we, wb_fwd_addr, wb_fwd_data);

  always_comb begin
    op_a = '0;
    case (ex_params_in.a_sel)
      SEL_REG: op_a = ra_val;
      SEL_IMM: op_a = ex_params_in.imm;
      SEL_PC:  op_a = ex_params_in.ia_plus_4;
      default: op_a = '0;
    endcase
  end

  // SEL_PC has no meaning for B and falls through to zero.
  always_comb begin
    op_b_raw = '0;
    case (ex_params_in.b_sel)
      SEL_REG: op_b_raw = rb_val;
      SEL_IMM: op_b_raw = ex_params_in.imm;
      default: op_b_raw = '0;
    endcase
  end

  assign op_b_shifted = op_b_raw << ex_params_in.shift;
  assign op_b         = ex_params_in.invert_b ? ~op_b_shifted : op_b_shifted;

  alu u_alu (
    .a        (op_a),
    .b        (op_b),
    .cin      (ex_params_in.invert_b),
    .alu_op   (ex_params_in.alu_op),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow)
  );

  // Compares assume the bundle asks for a subtract (ADD with invert_b).
  always_comb begin
    t_cmp = t_q;
    case (ex_params_in.t_op)
      T_OP_EQ:  t_cmp = (alu_result == '0);
      T_OP_LT:  t_cmp = alu_result[XLEN-1] ^ alu_overflow;
      T_OP_LTU: t_cmp = ~alu_carry;
      default:  t_cmp = t_q;
    endcase
  end

  assign t_next = t_cmp ^ ex_params_in.invert_t;

  // Branch decision sees the registered T, i.e. the older instruction's write.
  assign taken         = ex_params_in.branch & (~ex_params_in.cond_branch | t_q);
  assign redirect      = taken;
  assign valid         = ~taken;
  assign redirect_addr = alu_result;
  assign ex_result     = ex_params_in.branch ? ex_params_in.ia_plus_4 : alu_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q   <= 1'b0;
      mem_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      t_q              <= t_next;
      mem_q.mem_op     <= ex_params_in.mem_op;
      mem_q.result     <= ex_result;
      mem_q.store_data <= rb_val;
      mem_q.rd_addr    <= ex_params_in.rd_addr;
    end
  end

  assign t_flag         = t_q;
  assign mem_params_out = mem_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM bundles go into a scoreboard
// queue when a bundle is driven and are popped after the capturing edge.
module tb_ex_stage;
  import types_pkg::*;

  logic              clk;
  logic              rst_n;
  ex_params_t        ex_in;
  logic              mem_fwd_we, wb_fwd_we;
  logic [REG_AW-1:0] mem_fwd_addr, wb_fwd_addr;
  logic [XLEN-1:0]   mem_fwd_data, wb_fwd_data;
  logic              valid, redirect, t_flag;
  logic [XLEN-1:0]   redirect_addr;
  mem_params_t       mem_params_out;

  mem_params_t exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_params_in   (ex_in),
    .mem_fwd_we     (mem_fwd_we),
    .mem_fwd_addr   (mem_fwd_addr),
    .mem_fwd_data   (mem_fwd_data),
    .wb_fwd_we      (wb_fwd_we),
    .wb_fwd_addr    (wb_fwd_addr),
    .wb_fwd_data    (wb_fwd_data),
    .valid          (valid),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .t_flag         (t_flag),
    .mem_params_out (mem_params_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input mem_op_t op, input logic [31:0] res, input logic [31:0] sd,
                      input logic [4:0] rd);
    mem_params_t e;
    e.mem_op     = op;
    e.result     = res;
    e.store_data = sd;
    e.rd_addr    = rd;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    mem_params_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 96'(mem_params_out), 96'(e));
    end
  endtask

  ex_params_t  b;
  logic [31:0] tab_a   [9] = '{32'h8000_0000, 32'h8000_0010, 32'h0000_0001, 32'h8000_0000,
                               32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFF0,
                               32'h0000_0003};
  logic [31:0] tab_imm [9] = '{32'd31, 32'd0, 32'd1, 32'd31,
                               32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'h0000_0020,
                               32'h0000_0001};
  logic [4:0]  tab_sh  [9] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31};
  alu_op_t     tab_op  [9] = '{ALU_OP_SAR, ALU_OP_SAR, ALU_OP_SHL, ALU_OP_SHR,
                               ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_ADD, ALU_OP_ADD};
  logic [31:0] tab_exp [9] = '{32'hFFFF_FFFF, 32'h8000_0010, 32'h0001_0000, 32'h0000_0001,
                               32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h0000_0010,
                               32'h8000_0003};

  initial begin
    mem_fwd_we = 0; mem_fwd_addr = '0; mem_fwd_data = '0;
    wb_fwd_we  = 0; wb_fwd_addr  = '0; wb_fwd_data  = '0;

    // Reset while a live ADD (that would also toggle T) is presented.
    rst_n = 1'b0;
    b = '0;
    b.ra_addr = 5'd1; b.ra_data = 32'h1234_5678; b.a_sel = SEL_REG;
    b.b_sel = SEL_IMM; b.imm = 32'd1; b.rd_addr = 5'd5; b.mem_op = MEM_OP_STORE;
    b.invert_t = 1'b1;
    ex_in = b;
    push(MEM_OP_NONE, 32'h0, 32'h0, 5'd0);
    tick("reset_mp");
    check("reset_t", 96'(t_flag), 96'(1'b0));
    check("reset_valid", 96'(valid), 96'(1'b1));
    check("reset_redirect", 96'(redirect), 96'(1'b0));
    rst_n = 1'b1;

    // 0xFFFFFFFF + 1 wraps to zero; EQ sets T, then inverted EQ clears it.
    b = '0;
    b.ra_addr = 5'd1; b.ra_data = 32'hFFFF_FFFF; b.a_sel = SEL_REG;
    b.b_sel = SEL_IMM; b.imm = 32'd1; b.t_op = T_OP_EQ; b.rd_addr = 5'd2;
    ex_in = b;
    #1 check("add_valid", 96'(valid), 96'(1'b1));
    push(MEM_OP_NONE, 32'h0, 32'h0, 5'd2);
    tick("add_wrap_mp");
    check("eq_t", 96'(t_flag), 96'(1'b1));
    b.invert_t = 1'b1;
    ex_in = b;
    push(MEM_OP_NONE, 32'h0, 32'h0, 5'd2);
    tick("add_wrap_inv_mp");
    check("eq_inv_t", 96'(t_flag), 96'(1'b0));

    // Forwarding priority, ra==rb, and r0 never forwarded.
    b = '0;
    b.ra_addr = 5'd3; b.ra_data = 32'd7; b.rb_addr = 5'd3; b.rb_data = 32'd7;
    b.a_sel = SEL_REG; b.b_sel = SEL_ZERO; b.rd_addr = 5'd4; b.mem_op = MEM_OP_STORE;
    ex_in = b;
    mem_fwd_we = 1; mem_fwd_addr = 5'd3; mem_fwd_data = 32'd5;
    wb_fwd_we  = 1; wb_fwd_addr  = 5'd3; wb_fwd_data  = 32'd9;
    push(MEM_OP_STORE, 32'd5, 32'd5, 5'd4);
    tick("fwd_mem_mp");
    mem_fwd_we = 0;
    push(MEM_OP_STORE, 32'd9, 32'd9, 5'd4);
    tick("fwd_wb_mp");
    mem_fwd_we = 1; mem_fwd_addr = 5'd0; wb_fwd_addr = 5'd0;
    b.ra_addr = 5'd0; b.rb_addr = 5'd0;
    ex_in = b;
    push(MEM_OP_STORE, 32'd0, 32'd0, 5'd4);
    tick("fwd_r0_mp");
    mem_fwd_we = 0; wb_fwd_we = 0;

    // 0xFFFFFFFE - 1: unsigned not below, signed below.
    b = '0;
    b.ra_addr = 5'd1; b.ra_data = 32'hFFFF_FFFE; b.rb_addr = 5'd2; b.rb_data = 32'd1;
    b.a_sel = SEL_REG; b.b_sel = SEL_REG; b.invert_b = 1'b1; b.t_op = T_OP_LTU;
    b.rd_addr = 5'd5;
    ex_in = b;
    push(MEM_OP_NONE, 32'hFFFF_FFFD, 32'd1, 5'd5);
    tick("sub_ltu_mp");
    check("ltu_t", 96'(t_flag), 96'(1'b0));
    b.t_op = T_OP_LT;
    ex_in = b;
    push(MEM_OP_NONE, 32'hFFFF_FFFD, 32'd1, 5'd5);
    tick("sub_lt_mp");
    check("lt_t", 96'(t_flag), 96'(1'b1));

    // Taken conditional branch; its EQ update lands after the decision.
    b = '0;
    b.branch = 1'b1; b.cond_branch = 1'b1; b.a_sel = SEL_PC; b.ia_plus_4 = 32'h104;
    b.b_sel = SEL_IMM; b.imm = 32'h20; b.rd_addr = 5'd31; b.t_op = T_OP_EQ;
    ex_in = b;
    #1;
    check("br_taken_redirect", 96'(redirect), 96'(1'b1));
    check("br_taken_addr", 96'(redirect_addr), 96'(32'h124));
    check("br_taken_valid", 96'(valid), 96'(1'b0));
    push(MEM_OP_NONE, 32'h104, 32'h0, 5'd31);
    tick("br_link_mp");
    check("br_t_after", 96'(t_flag), 96'(1'b0));
    #1;
    check("br_nt_redirect", 96'(redirect), 96'(1'b0));
    check("br_nt_valid", 96'(valid), 96'(1'b1));
    push(MEM_OP_NONE, 32'h104, 32'h0, 5'd31);
    tick("br_nt_mp");

    // Set T, then hold it through bubbles, then clear with inverted SET.
    b = '0; b.invert_t = 1'b1;
    ex_in = b;
    push(MEM_OP_NONE, 32'h0, 32'h0, 5'd0);
    tick("set_t_mp");
    check("set_t", 96'(t_flag), 96'(1'b1));
    b = '0;
    ex_in = b;
    for (int i = 0; i < 3; i++) begin
      push(MEM_OP_NONE, 32'h0, 32'h0, 5'd0);
      tick($sformatf("bubble%0d_mp", i));
      check($sformatf("bubble%0d_t", i), 96'(t_flag), 96'(1'b1));
      check($sformatf("bubble%0d_memop", i), 96'(mem_params_out.mem_op), 96'(MEM_OP_NONE));
    end
    b.invert_t = 1'b1;
    ex_in = b;
    push(MEM_OP_NONE, 32'h0, 32'h0, 5'd0);
    tick("clr_t_mp");
    check("clr_t", 96'(t_flag), 96'(1'b0));

    // ALU op table, including shift-field on B and SAR boundaries.
    for (int i = 0; i < 9; i++) begin
      b = '0;
      b.ra_addr = 5'd1; b.ra_data = tab_a[i]; b.a_sel = SEL_REG;
      b.b_sel = SEL_IMM; b.imm = tab_imm[i]; b.shift = tab_sh[i];
      b.alu_op = tab_op[i]; b.rd_addr = 5'd6; b.mem_op = MEM_OP_LOAD;
      ex_in = b;
      push(MEM_OP_LOAD, tab_exp[i], 32'h0, 5'd6);
      tick($sformatf("alu%0d_mp", i));
    end

    // SEL_PC on B reads as zero.
    b = '0;
    b.ra_addr = 5'd1; b.ra_data = 32'd5; b.a_sel = SEL_REG;
    b.b_sel = SEL_PC; b.ia_plus_4 = 32'h100; b.rd_addr = 5'd7;
    ex_in = b;
    push(MEM_OP_NONE, 32'd5, 32'h0, 5'd7);
    tick("b_pc_zero_mp");

    // Reset beats a taken branch that would also set T.
    rst_n = 1'b0;
    b = '0;
    b.branch = 1'b1; b.a_sel = SEL_PC; b.ia_plus_4 = 32'h200; b.b_sel = SEL_IMM;
    b.imm = 32'h40; b.rd_addr = 5'd31; b.mem_op = MEM_OP_STORE; b.invert_t = 1'b1;
    ex_in = b;
    push(MEM_OP_NONE, 32'h0, 32'h0, 5'd0);
    tick("reset_br_mp");
    check("reset_br_t", 96'(t_flag), 96'(1'b0));
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
